pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised program-counter unit; next generation of the core's PC register and next-PC mux.
- Holds the PC and selects next PC from sequential increment, branch target, jump target or trap vector.
- Presents the PC to instruction fetch over a valid/ready handshake.
- Adds a boot/run/halt state machine, stall handling and misaligned-target trapping.

Parameters:
XLEN, 32, PC/address width in bits
INC, 4, sequential increment added per accepted fetch
RESET_VEC, 32'h0000_0000, PC loaded at reset
ALIGN_BITS, 2, low target bits that must be zero; 0 disables the check
RAS_DEPTH, 4, return-address-stack entries (only with RAS_EN)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
fetch_valid  out  1  pc is a valid fetch request
fetch_ready  in  1  fetch accepts request this cycle
pc  out  XLEN  current PC
redirect_valid  in  1  apply redirect this cycle
redirect_sel  in  2  00 none, 01 branch, 10 jump, 11 trap
branch_target  in  XLEN  branch destination
jump_target  in  XLEN  jump destination
trap_vec  in  XLEN  trap handler address
halt_req  in  1  level request to stop fetching
halted  out  1  unit is in HALT
misalign_err  out  1  one-cycle pulse, misaligned redirect target
err_addr  out  XLEN  last offending target

Behaviour:
- Reset (async assert): state=BOOT, pc=RESET_VEC, fetch_valid=0, halted=0, misalign_err=0, err_addr=0.
- BOOT: exactly one cycle after reset release, then RUN. No PC change in BOOT.
- RUN: fetch_valid=1.
- HALT: fetch_valid=0, halted=1.
- RUN->HALT: when halt_req=1 at a clock edge. A handshake completing on the same edge still advances pc.
- HALT->RUN: when halt_req=0. pc is the next unfetched address.
- Next-PC priority, highest first:
  - trap (redirect_valid & sel=11) -> trap_vec
  - branch (01) -> branch_target
  - jump (10) -> jump_target
  - accepted fetch (fetch_valid & fetch_ready) -> pc+INC
  - otherwise hold
- sel=00 with redirect_valid is a no-op.
- Redirects apply in RUN and HALT, including during a stall (fetch_valid & !fetch_ready). The unaccepted request is dropped; no extra stall cycle.
- Misaligned branch/jump target (target[ALIGN_BITS-1:0]!=0):
  - pc=trap_vec
  - misalign_err=1 for one cycle
  - err_addr=target
- trap_vec itself is never alignment-checked.
- Arithmetic: pc+INC wraps modulo 2^XLEN (e.g. 32'hFFFF_FFFC+4 -> 0). No flag.
- Latency: every update is visible one cycle after the deciding edge. pc is registered; no combinational input->pc path.
- Reset mid-operation: immediate return to BOOT/RESET_VEC regardless of state.

Optional Feature:
- Macro RAS_EN adds a return-address stack.
- With RAS_EN, extra ports:
  - ras_push in 1, with ras_push_addr in XLEN
  - ras_pop in 1
  - ras_underflow out 1
- Pop priority: below trap/branch/jump, above sequential. A pop sets pc to the top entry and decrements the count.
- Push when full overwrites the oldest entry (circular); count saturates at RAS_DEPTH.
- Simultaneous push and pop: pc takes the old top, then the new address replaces it; count unchanged.
- Pop on empty: sequential/hold rule applies; ras_underflow pulses one cycle.
- Stack is cleared by reset.
- Without RAS_EN: these ports and the storage do not exist; behaviour is exactly as above.

Test Plan:
- Reset release, fetch_ready=1 -> BOOT one cycle with pc=0, fetch_valid=0; then pc=0,4,8,12 on consecutive cycles.
- fetch_ready=0 for 3 cycles at pc=8 -> pc holds 8, fetch_valid=1; branch_target=0x100 redirect during the stall -> next cycle pc=0x100.
- Same cycle: redirect sel=11 (trap_vec=0x80) and fetch accept -> pc=0x80; trap beats sequential.
- Jump to 0x102 with ALIGN_BITS=2 -> pc=trap_vec, misalign_err high one cycle, err_addr=0x102.
- pc=0xFFFF_FFFC, accept -> pc=0. Separately, halt_req=1 with fetch_ready=1 at pc=0x20 -> pc=0x24, halted=1; drop halt_req -> fetch resumes at 0x24.
- RAS_EN: push 0x40, 0x50, then pop -> pc=0x50, pop -> pc=0x40, pop -> ras_underflow=1 and pc advances sequentially.

Source files
------------

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with boot/run/halt control, redirect mux and misaligned-target trapping; optional return-address stack under RAS_EN
module pc_unit #(
  parameter int              XLEN       = 32,
  parameter int              INC        = 4,
  parameter logic [XLEN-1:0] RESET_VEC  = '0,
  parameter int              ALIGN_BITS = 2
`ifdef RAS_EN
  , parameter int            RAS_DEPTH  = 4
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] pc,
  input  logic            redirect_valid,
  input  logic [1:0]      redirect_sel,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jump_target,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            halt_req,
  output logic            halted,
  output logic            misalign_err,
  output logic [XLEN-1:0] err_addr
`ifdef RAS_EN
  ,
  input  logic            ras_push,
  input  logic [XLEN-1:0] ras_push_addr,
  input  logic            ras_pop,
  output logic            ras_underflow
`endif
);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_e;

  // Low address bits that must be clear on a branch/jump target; all-zero when ALIGN_BITS is 0.
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] err_addr_q, err_addr_d;

  logic            active;
  logic            accept;
  logic            redirect_hit;
  logic            ras_take;
  logic [XLEN-1:0] ras_top;

  assign active       = (state_q != ST_BOOT);
  assign fetch_valid  = (state_q == ST_RUN);
  assign halted       = (state_q == ST_HALT);
  assign accept       = fetch_valid & fetch_ready;
  assign redirect_hit = redirect_valid & (redirect_sel != 2'b00);
  assign pc           = pc_q;
  assign misalign_err = err_q;
  assign err_addr     = err_addr_q;

`ifdef RAS_EN
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0]   wp_q, top_idx, wp_inc;
  logic [CW-1:0]   cnt_q;
  logic            ras_uf_q;
  logic            ras_pop_ok;

  // wp_q is the next write slot; the top entry sits one slot behind it, circularly.
  assign top_idx       = (wp_q == '0) ? PW'(RAS_DEPTH - 1) : wp_q - PW'(1);
  assign wp_inc        = (wp_q == PW'(RAS_DEPTH - 1)) ? '0 : wp_q + PW'(1);
  assign ras_pop_ok    = active & ras_pop & ~redirect_hit;
  assign ras_take      = ras_pop_ok & (cnt_q != '0);
  assign ras_top       = ras_q[top_idx];
  assign ras_underflow = ras_uf_q;

  // Stack storage: push+pop replaces the top in place, a lone push overwrites the oldest when full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
      wp_q     <= '0;
      cnt_q    <= '0;
      ras_uf_q <= 1'b0;
    end else begin
      ras_uf_q <= ras_pop_ok & (cnt_q == '0);
      if (active & ras_push & ras_take) begin
        ras_q[top_idx] <= ras_push_addr;
      end else if (active & ras_push) begin
        ras_q[wp_q] <= ras_push_addr;
        wp_q        <= wp_inc;
        if (cnt_q != CW'(RAS_DEPTH)) cnt_q <= cnt_q + CW'(1);
      end else if (ras_take) begin
        wp_q  <= top_idx;
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end
`else
  assign ras_take = 1'b0;
  assign ras_top  = '0;
`endif

  // Next state, next PC and misalignment pulse; redirects are ignored only while booting.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    err_d      = 1'b0;
    err_addr_d = err_addr_q;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  if (halt_req)  state_d = ST_HALT;
      ST_HALT: if (!halt_req) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
    if (active) begin
      if (redirect_valid && redirect_sel == 2'b11) begin
        pc_d = trap_vec;
      end else if (redirect_valid && redirect_sel == 2'b01) begin
        if ((branch_target & ALIGN_MASK) != '0) begin
          pc_d       = trap_vec;
          err_d      = 1'b1;
          err_addr_d = branch_target;
        end else begin
          pc_d = branch_target;
        end
      end else if (redirect_valid && redirect_sel == 2'b10) begin
        if ((jump_target & ALIGN_MASK) != '0) begin
          pc_d       = trap_vec;
          err_d      = 1'b1;
          err_addr_d = jump_target;
        end else begin
          pc_d = jump_target;
        end
      end else if (ras_take) begin
        pc_d = ras_top;
      end else if (accept) begin
        pc_d = pc_q + XLEN'(INC);
      end
    end
  end

  // Architectural state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VEC;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - self-checking bench for pc_unit: directed scenarios plus randomized traffic against a reference model
module tb_pc_unit;
  localparam int XLEN  = 32;
  localparam int INC   = 4;
  localparam int ALIGN = 2;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            fetch_valid, fetch_ready;
  logic [XLEN-1:0] pc;
  logic            redirect_valid;
  logic [1:0]      redirect_sel;
  logic [XLEN-1:0] branch_target, jump_target, trap_vec;
  logic            halt_req, halted, misalign_err;
  logic [XLEN-1:0] err_addr;
  logic            ras_push, ras_pop, ras_underflow;
  logic [XLEN-1:0] ras_push_addr;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 0;

  pc_unit #(.XLEN(XLEN), .INC(INC), .RESET_VEC(32'h0), .ALIGN_BITS(ALIGN)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .pc(pc),
    .redirect_valid(redirect_valid), .redirect_sel(redirect_sel), .branch_target(branch_target),
    .jump_target(jump_target), .trap_vec(trap_vec), .halt_req(halt_req), .halted(halted),
    .misalign_err(misalign_err), .err_addr(err_addr)
`ifdef RAS_EN
    , .ras_push(ras_push), .ras_push_addr(ras_push_addr), .ras_pop(ras_pop), .ras_underflow(ras_underflow)
`endif
  );

`ifndef RAS_EN
  assign ras_underflow = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: 0 = booting, 1 = running, 2 = halted.
  int              m_state;
  logic [31:0]     m_pc, m_eaddr, m_nxt, m_t;
  bit              m_err, m_uf, m_popped, m_acc;
  logic [31:0]     rq[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_pc = 32'h0; m_err = 0; m_uf = 0; m_eaddr = 32'h0;
      rq.delete();
    end else begin
      m_err = 0; m_uf = 0;
      if (m_state == 0) begin
        m_state = 1;
      end else begin
        m_acc = (m_state == 1) && fetch_ready;
        m_nxt = m_pc;
        m_popped = 0;
        if (redirect_valid && redirect_sel == 2'd3) begin
          m_nxt = trap_vec;
        end else if (redirect_valid && redirect_sel != 2'd0) begin
          m_t = (redirect_sel == 2'd1) ? branch_target : jump_target;
          if (m_t % (1 << ALIGN) != 0) begin
            m_nxt = trap_vec; m_err = 1; m_eaddr = m_t;
          end else begin
            m_nxt = m_t;
          end
        end else begin
`ifdef RAS_EN
          if (ras_pop) begin
            if (rq.size() > 0) begin m_nxt = rq[$]; m_popped = 1; end
            else m_uf = 1;
          end
`endif
          if (!m_popped && m_acc) m_nxt = m_pc + INC;
        end
`ifdef RAS_EN
        if (m_popped && ras_push) rq[rq.size()-1] = ras_push_addr;
        else if (m_popped) void'(rq.pop_back());
        else if (ras_push) begin
          if (rq.size() == DEPTH) void'(rq.pop_front());
          rq.push_back(ras_push_addr);
        end
`endif
        m_pc = m_nxt;
        if (m_state == 1 && halt_req) m_state = 2;
        else if (m_state == 2 && !halt_req) m_state = 1;
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m.pc", pc, m_pc);
      chk("m.fetch_valid", {31'b0, fetch_valid}, {31'b0, m_state == 1});
      chk("m.halted", {31'b0, halted}, {31'b0, m_state == 2});
      chk("m.misalign_err", {31'b0, misalign_err}, {31'b0, m_err});
      chk("m.err_addr", err_addr, m_eaddr);
      chk("m.ras_underflow", {31'b0, ras_underflow}, {31'b0, m_uf});
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    fetch_ready = 1; redirect_valid = 0; redirect_sel = 0;
    branch_target = 0; jump_target = 0; trap_vec = 0; halt_req = 0;
    ras_push = 0; ras_pop = 0; ras_push_addr = 0;
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = $urandom;
    if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
    return t;
  endfunction

  initial begin
    idle_inputs();
    tick(); tick();
    chk_en = 1;
    chk("rst.pc", pc, 32'h0);
    chk("rst.fetch_valid", {31'b0, fetch_valid}, 32'h0);
    chk("rst.halted", {31'b0, halted}, 32'h0);
    chk("rst.err", {31'b0, misalign_err}, 32'h0);
    chk("rst.err_addr", err_addr, 32'h0);

    #2 rst_n = 1;
    #1 chk("boot.fetch_valid", {31'b0, fetch_valid}, 32'h0);
    chk("boot.pc", pc, 32'h0);
    tick(); chk("seq0", pc, 32'h0); chk("seq0.valid", {31'b0, fetch_valid}, 32'h1);
    tick(); chk("seq4", pc, 32'h4);
    tick(); chk("seq8", pc, 32'h8);
    fetch_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("stall.pc", pc, 32'h8); chk("stall.valid", {31'b0, fetch_valid}, 32'h1);
    end
    redirect_valid = 1; redirect_sel = 2'b01; branch_target = 32'h100;
    tick(); chk("stall.branch", pc, 32'h100);
    fetch_ready = 1; redirect_sel = 2'b11; trap_vec = 32'h80;
    tick(); chk("trap.beats.seq", pc, 32'h80);
    redirect_sel = 2'b10; jump_target = 32'h102;
    tick(); chk("misalign.pc", pc, 32'h80);
    chk("misalign.err", {31'b0, misalign_err}, 32'h1);
    chk("misalign.addr", err_addr, 32'h102);
    redirect_valid = 0;
    tick(); chk("misalign.pulse", {31'b0, misalign_err}, 32'h0); chk("post.trap.seq", pc, 32'h84);
    redirect_valid = 1; redirect_sel = 2'b01; branch_target = 32'hFFFF_FFFC;
    tick(); chk("wrap.pre", pc, 32'hFFFF_FFFC);
    redirect_valid = 0;
    tick(); chk("wrap", pc, 32'h0);
    redirect_valid = 1; redirect_sel = 2'b00;
    tick(); chk("sel00.noop", pc, 32'h4);
    redirect_sel = 2'b01; branch_target = 32'h20;
    tick(); chk("halt.pre", pc, 32'h20);
    redirect_valid = 0; halt_req = 1;
    tick(); chk("halt.pc", pc, 32'h24); chk("halt.flag", {31'b0, halted}, 32'h1);
    chk("halt.valid", {31'b0, fetch_valid}, 32'h0);
    tick(); chk("halt.hold", pc, 32'h24);
    halt_req = 0;
    tick(); chk("resume.pc", pc, 32'h24); chk("resume.flag", {31'b0, halted}, 32'h0);
    tick(); chk("resume.seq", pc, 32'h28);
`ifdef RAS_EN
    ras_push = 1; ras_push_addr = 32'h40;
    tick();
    ras_push_addr = 32'h50;
    tick();
    ras_push = 0; ras_pop = 1;
    tick(); chk("ras.pop1", pc, 32'h50);
    tick(); chk("ras.pop2", pc, 32'h40);
    tick(); chk("ras.uf", {31'b0, ras_underflow}, 32'h1); chk("ras.uf.seq", pc, 32'h44);
    ras_pop = 0;
    tick(); chk("ras.uf.pulse", {31'b0, ras_underflow}, 32'h0);
`endif
    #2 rst_n = 0;
    #1 chk("midrst.pc", pc, 32'h0); chk("midrst.valid", {31'b0, fetch_valid}, 32'h0);
    chk("midrst.halted", {31'b0, halted}, 32'h0);
    tick(); #2 rst_n = 1;

    for (int c = 0; c < 3000; c++) begin
      tick();
      fetch_ready    = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 3) == 0);
      redirect_sel   = 2'($urandom_range(0, 3));
      branch_target  = rand_target();
      jump_target    = rand_target();
      trap_vec       = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 19) == 0) halt_req = ~halt_req;
      ras_push       = ($urandom_range(0, 6) == 0);
      ras_pop        = ($urandom_range(0, 6) == 0);
      ras_push_addr  = $urandom;
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 0;
        tick(); #2 rst_n = 1;
      end
    end
    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
